// File: rtl/sat_lvl_ctrl.sv
// Level/phase controller for one Sat Engine bin.
// Holds the base level, the local decision level L and a per-level table of
// (valid, bin, decided var), and sequences the decide / imply / analyze /
// backtrack phases, including the cross-bin backtrack target computation.
module sat_lvl_ctrl #(
    parameter int NUM_VARS        = 8,
    parameter int NUM_LVLS        = 8,
    parameter int WIDTH_LVL       = 16,
    parameter int WIDTH_BIN       = 10,
    parameter int IMPLY_SETTLE    = 2,
    parameter int ANALYZE_TIMEOUT = 64,
    localparam int LW             = $clog2(NUM_LVLS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 base_lvl_en,
    input  logic [WIDTH_LVL-1:0] base_lvl_i,
    input  logic [WIDTH_BIN-1:0] cur_bin_num_i,
    input  logic                 start_decision_i,
    input  logic [NUM_VARS-1:0]  decide_index_i,
    input  logic                 decide_none_i,
    output logic                 done_decision_o,
    output logic                 sat_local_o,
    output logic                 lvl_full_o,
    output logic [WIDTH_LVL-1:0] cur_lvl_o,
    output logic [LW-1:0]        local_lvl_o,
    input  logic                 apply_imply_i,
    input  logic [NUM_VARS-1:0]  find_imply_i,
    input  logic [NUM_VARS-1:0]  find_conflict_i,
    output logic                 done_imply_o,
    output logic                 conflict_o,
    input  logic                 apply_analyze_i,
    input  logic                 learnt_valid_i,
    input  logic [WIDTH_LVL-1:0] learnt_max_lvl_i,
    output logic                 add_learntc_en_o,
    output logic                 done_analyze_o,
    output logic                 analyze_timeout_o,
    output logic [WIDTH_LVL-1:0] bkt_lvl_o,
    output logic [WIDTH_BIN-1:0] bkt_bin_o,
    output logic                 bkt_cross_bin_o,
    output logic                 lvl_clamp_o,
    input  logic                 apply_bkt_i,
    output logic                 done_bkt_o,
    output logic                 busy_o
);

    localparam int SW = $clog2(IMPLY_SETTLE + 1);
    localparam int TW = $clog2(ANALYZE_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_DECIDE, S_IMPLY, S_FIND, S_ADD, S_ADONE, S_BKT
    } state_t;

    state_t                state_q, state_d;
    logic [WIDTH_LVL-1:0]  base_q, base_d;
    logic [LW-1:0]         l_q, l_d;
    logic [NUM_LVLS:1]     valid_q, valid_d;
    logic [WIDTH_BIN-1:0]  bin_q [1:NUM_LVLS];
    logic [WIDTH_BIN-1:0]  bin_d [1:NUM_LVLS];
    logic [NUM_VARS-1:0]   idx_q [1:NUM_LVLS];
    logic [NUM_VARS-1:0]   idx_d [1:NUM_LVLS];
    logic [SW-1:0]         settle_q, settle_d;
    logic [NUM_VARS-1:0]   prev_imply_q, prev_imply_d;
    logic [TW-1:0]         tcnt_q, tcnt_d;
    logic [LW-1:0]         tgt_q, tgt_d;
    logic                  cross_q, cross_d;
    logic                  clamp_q, clamp_d;
    logic [WIDTH_LVL-1:0]  bkt_lvl_q, bkt_lvl_d;
    logic [WIDTH_BIN-1:0]  bkt_bin_q, bkt_bin_d;
    logic                  timeout_q, timeout_d;
    logic                  done_dec_q, done_dec_d;
    logic                  sat_q, sat_d;
    logic                  full_q, full_d;
    logic                  done_imp_q, done_imp_d;
    logic                  conflict_q, conflict_d;
    logic                  add_q, add_d;
    logic                  done_ana_q, done_ana_d;
    logic                  done_bkt_q, done_bkt_d;
    logic                  busy_q, busy_d;

    logic [LW-1:0]         l_inc;
    logic [WIDTH_LVL-1:0]  t_full;
    logic [LW-1:0]         t_loc;
    logic [WIDTH_BIN-1:0]  bin_sel;

    // Next-state logic: requests are only taken in IDLE, every done/en is a one-cycle pulse
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        l_d          = l_q;
        valid_d      = valid_q;
        bin_d        = bin_q;
        idx_d        = idx_q;
        settle_d     = settle_q;
        prev_imply_d = find_imply_i;
        tcnt_d       = tcnt_q;
        tgt_d        = tgt_q;
        cross_d      = cross_q;
        clamp_d      = clamp_q;
        bkt_lvl_d    = bkt_lvl_q;
        bkt_bin_d    = bkt_bin_q;
        timeout_d    = timeout_q;
        done_dec_d   = 1'b0;
        sat_d        = 1'b0;
        full_d       = 1'b0;
        done_imp_d   = 1'b0;
        conflict_d   = 1'b0;
        add_d        = 1'b0;
        done_ana_d   = 1'b0;
        done_bkt_d   = 1'b0;
        l_inc        = l_q + LW'(1);
        t_full       = learnt_max_lvl_i - base_q;
        t_loc        = '0;
        bin_sel      = cur_bin_num_i;

        case (state_q)
            S_IDLE: begin
                if (base_lvl_en) base_d = base_lvl_i;
                if (apply_bkt_i) begin
                    state_d = S_BKT;
                end else if (apply_analyze_i) begin
                    state_d   = S_FIND;
                    timeout_d = 1'b0;
                    tcnt_d    = '0;
                    clamp_d   = 1'b0;
                end else if (apply_imply_i) begin
                    state_d  = S_IMPLY;
                    settle_d = '0;
                end else if (start_decision_i) begin
                    state_d = S_DECIDE;
                end
            end
            S_DECIDE: begin
                state_d    = S_IDLE;
                done_dec_d = 1'b1;
                if (decide_none_i) begin
                    sat_d = 1'b1;
                end else if (l_q == LW'(NUM_LVLS)) begin
                    full_d = 1'b1;
                end else begin
                    l_d = l_inc;
                    for (int i = 1; i <= NUM_LVLS; i++) begin
                        if (LW'(i) == l_inc) begin
                            valid_d[i] = 1'b1;
                            bin_d[i]   = cur_bin_num_i;
                            idx_d[i]   = decide_index_i;
                        end
                    end
                end
            end
            S_IMPLY: begin
                if (|find_conflict_i) begin
                    state_d    = S_IDLE;
                    done_imp_d = 1'b1;
                    conflict_d = 1'b1;
                end else if (find_imply_i == prev_imply_q) begin
                    if (settle_q == SW'(IMPLY_SETTLE - 1)) begin
                        state_d    = S_IDLE;
                        done_imp_d = 1'b1;
                    end else begin
                        settle_d = settle_q + SW'(1);
                    end
                end else begin
                    settle_d = '0;
                end
            end
            S_FIND: begin
                if (learnt_valid_i) begin
                    state_d = S_ADD;
                    add_d   = 1'b1;
                    if (learnt_max_lvl_i <= base_q) begin
                        cross_d   = 1'b1;
                        tgt_d     = '0;
                        bkt_lvl_d = learnt_max_lvl_i;
                        bkt_bin_d = cur_bin_num_i;
                    end else begin
                        if (t_full > WIDTH_LVL'(l_q)) begin
                            t_loc   = l_q;
                            clamp_d = 1'b1;
                        end else begin
                            t_loc = t_full[LW-1:0];
                        end
                        for (int i = 1; i <= NUM_LVLS; i++) begin
                            if (LW'(i) == t_loc) bin_sel = bin_q[i];
                        end
                        cross_d   = 1'b0;
                        tgt_d     = t_loc;
                        bkt_lvl_d = base_q + WIDTH_LVL'(t_loc);
                        bkt_bin_d = bin_sel;
                    end
                end else if (tcnt_q == TW'(ANALYZE_TIMEOUT - 1)) begin
                    state_d    = S_ADONE;
                    timeout_d  = 1'b1;
                    done_ana_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            S_ADD: begin
                state_d    = S_ADONE;
                done_ana_d = 1'b1;
            end
            S_ADONE: begin
                state_d = S_IDLE;
            end
            S_BKT: begin
                state_d    = S_IDLE;
                done_bkt_d = 1'b1;
                if (cross_q) begin
                    l_d     = '0;
                    valid_d = '0;
                end else begin
                    l_d = tgt_q;
                    for (int i = 1; i <= NUM_LVLS; i++) begin
                        if (LW'(i) > tgt_q) valid_d[i] = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE) | done_dec_d | done_imp_d | done_ana_d | done_bkt_d;
    end

    // State register with asynchronous active-low clear of everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            l_q          <= '0;
            valid_q      <= '0;
            for (int i = 1; i <= NUM_LVLS; i++) begin
                bin_q[i] <= '0;
                idx_q[i] <= '0;
            end
            settle_q     <= '0;
            prev_imply_q <= '0;
            tcnt_q       <= '0;
            tgt_q        <= '0;
            cross_q      <= 1'b0;
            clamp_q      <= 1'b0;
            bkt_lvl_q    <= '0;
            bkt_bin_q    <= '0;
            timeout_q    <= 1'b0;
            done_dec_q   <= 1'b0;
            sat_q        <= 1'b0;
            full_q       <= 1'b0;
            done_imp_q   <= 1'b0;
            conflict_q   <= 1'b0;
            add_q        <= 1'b0;
            done_ana_q   <= 1'b0;
            done_bkt_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            l_q          <= l_d;
            valid_q      <= valid_d;
            bin_q        <= bin_d;
            idx_q        <= idx_d;
            settle_q     <= settle_d;
            prev_imply_q <= prev_imply_d;
            tcnt_q       <= tcnt_d;
            tgt_q        <= tgt_d;
            cross_q      <= cross_d;
            clamp_q      <= clamp_d;
            bkt_lvl_q    <= bkt_lvl_d;
            bkt_bin_q    <= bkt_bin_d;
            timeout_q    <= timeout_d;
            done_dec_q   <= done_dec_d;
            sat_q        <= sat_d;
            full_q       <= full_d;
            done_imp_q   <= done_imp_d;
            conflict_q   <= conflict_d;
            add_q        <= add_d;
            done_ana_q   <= done_ana_d;
            done_bkt_q   <= done_bkt_d;
            busy_q       <= busy_d;
        end
    end

    assign done_decision_o   = done_dec_q;
    assign sat_local_o       = sat_q;
    assign lvl_full_o        = full_q;
    assign cur_lvl_o         = base_q + WIDTH_LVL'(l_q);
    assign local_lvl_o       = l_q;
    assign done_imply_o      = done_imp_q;
    assign conflict_o        = conflict_q;
    assign add_learntc_en_o  = add_q;
    assign done_analyze_o    = done_ana_q;
    assign analyze_timeout_o = timeout_q;
    assign bkt_lvl_o         = bkt_lvl_q;
    assign bkt_bin_o         = bkt_bin_q;
    assign bkt_cross_bin_o   = cross_q;
    assign lvl_clamp_o       = clamp_q;
    assign done_bkt_o        = done_bkt_q;
    assign busy_o            = busy_q;

endmodule

// File: tb/tb_sat_lvl_ctrl.sv
// Self-checking bench for sat_lvl_ctrl: a decision vector table plus
// hand-written imply, analyze, backtrack, priority and reset sequences.
module tb_sat_lvl_ctrl;

   logic        clk;
   logic        rst_n;
   logic        base_lvl_en;
   logic [15:0] base_lvl_i;
   logic [9:0]  cur_bin_num_i;
   logic        start_decision_i;
   logic [7:0]  decide_index_i;
   logic        decide_none_i;
   logic        done_decision_o;
   logic        sat_local_o;
   logic        lvl_full_o;
   logic [15:0] cur_lvl_o;
   logic [3:0]  local_lvl_o;
   logic        apply_imply_i;
   logic [7:0]  find_imply_i;
   logic [7:0]  find_conflict_i;
   logic        done_imply_o;
   logic        conflict_o;
   logic        apply_analyze_i;
   logic        learnt_valid_i;
   logic [15:0] learnt_max_lvl_i;
   logic        add_learntc_en_o;
   logic        done_analyze_o;
   logic        analyze_timeout_o;
   logic [15:0] bkt_lvl_o;
   logic [9:0]  bkt_bin_o;
   logic        bkt_cross_bin_o;
   logic        lvl_clamp_o;
   logic        apply_bkt_i;
   logic        done_bkt_o;
   logic        busy_o;

   sat_lvl_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .base_lvl_en(base_lvl_en), .base_lvl_i(base_lvl_i),
      .cur_bin_num_i(cur_bin_num_i),
      .start_decision_i(start_decision_i), .decide_index_i(decide_index_i),
      .decide_none_i(decide_none_i), .done_decision_o(done_decision_o),
      .sat_local_o(sat_local_o), .lvl_full_o(lvl_full_o),
      .cur_lvl_o(cur_lvl_o), .local_lvl_o(local_lvl_o),
      .apply_imply_i(apply_imply_i), .find_imply_i(find_imply_i),
      .find_conflict_i(find_conflict_i), .done_imply_o(done_imply_o),
      .conflict_o(conflict_o),
      .apply_analyze_i(apply_analyze_i), .learnt_valid_i(learnt_valid_i),
      .learnt_max_lvl_i(learnt_max_lvl_i), .add_learntc_en_o(add_learntc_en_o),
      .done_analyze_o(done_analyze_o), .analyze_timeout_o(analyze_timeout_o),
      .bkt_lvl_o(bkt_lvl_o), .bkt_bin_o(bkt_bin_o),
      .bkt_cross_bin_o(bkt_cross_bin_o), .lvl_clamp_o(lvl_clamp_o),
      .apply_bkt_i(apply_bkt_i), .done_bkt_o(done_bkt_o), .busy_o(busy_o)
   );

   typedef struct {
      logic [7:0]  idx;
      logic        none;
      logic [9:0]  bin;
      logic        expSat;
      logic        expFull;
      logic [3:0]  expL;
      logic [15:0] expCur;
   } dec_vec_t;

   dec_vec_t vecs [10];

   int testsRun  = 0;
   int testsFail = 0;

   int cyc;
   int cntDec, cntImp, cntAdd, cntAna, cntBkt;
   int latDec, latImp, latAdd, latAna, latBkt;
   logic satSeen, fullSeen, confSeen;

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: count it, report it if it does not match
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance one clock and settle just after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Forget all observed pulses; the current cycle becomes cycle 0
   task automatic clearObs();
      cyc = 0;
      cntDec = 0; cntImp = 0; cntAdd = 0; cntAna = 0; cntBkt = 0;
      latDec = -1; latImp = -1; latAdd = -1; latAna = -1; latBkt = -1;
      satSeen = 1'b0; fullSeen = 1'b0; confSeen = 1'b0;
   endtask

   // Run n cycles recording count, first latency and qualifiers of every pulse
   task automatic stepObs(input int n);
      repeat (n) begin
         tick();
         cyc++;
         if (done_decision_o) begin
            cntDec++;
            if (latDec < 0) latDec = cyc;
            satSeen = sat_local_o;
            fullSeen = lvl_full_o;
         end
         if (done_imply_o) begin
            cntImp++;
            if (latImp < 0) latImp = cyc;
            confSeen = conflict_o;
         end
         if (add_learntc_en_o) begin
            cntAdd++;
            if (latAdd < 0) latAdd = cyc;
         end
         if (done_analyze_o) begin
            cntAna++;
            if (latAna < 0) latAna = cyc;
         end
         if (done_bkt_o) begin
            cntBkt++;
            if (latBkt < 0) latBkt = cyc;
         end
      end
   endtask

   // Issue one decision request described by a table record
   task automatic applyStimulus(input dec_vec_t v);
      decide_index_i   = v.idx;
      decide_none_i    = v.none;
      cur_bin_num_i    = v.bin;
      start_decision_i = 1'b1;
      clearObs();
      stepObs(1);
      start_decision_i = 1'b0;
      stepObs(4);
      decide_none_i = 1'b0;
   endtask

   // Load the base level while idle
   task automatic loadBase(input logic [15:0] v);
      base_lvl_en = 1'b1;
      base_lvl_i  = v;
      tick();
      base_lvl_en = 1'b0;
   endtask

   // Pulse reset away from the clock edge
   task automatic doReset();
      rst_n = 1'b0;
      #2;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   // Analyze request; learnt result presented during cycle k (k>=1), or never when k==0
   task automatic doAnalyze(input int k, input logic [15:0] tmax);
      learnt_max_lvl_i = tmax;
      apply_analyze_i  = 1'b1;
      clearObs();
      stepObs(1);
      apply_analyze_i = 1'b0;
      if (k > 0) begin
         stepObs(k - 1);
         learnt_valid_i = 1'b1;
         stepObs(1);
         learnt_valid_i = 1'b0;
         stepObs(6);
      end else begin
         stepObs(80);
      end
   endtask

   // Backtrack request, optionally together with a decision request
   task automatic doBkt(input logic withDecide);
      apply_bkt_i      = 1'b1;
      start_decision_i = withDecide;
      clearObs();
      stepObs(1);
      apply_bkt_i      = 1'b0;
      start_decision_i = 1'b0;
      stepObs(4);
   endtask

   // Main sequence
   initial begin
      rst_n = 1'b1;
      base_lvl_en = 1'b0; base_lvl_i = '0; cur_bin_num_i = '0;
      start_decision_i = 1'b0; decide_index_i = '0; decide_none_i = 1'b0;
      apply_imply_i = 1'b0; find_imply_i = '0; find_conflict_i = '0;
      apply_analyze_i = 1'b0; learnt_valid_i = 1'b0; learnt_max_lvl_i = '0;
      apply_bkt_i = 1'b0;

      // Reset values
      #3 rst_n = 1'b0;
      #20;
      checkOutput("rst done_decision", 32'(done_decision_o), 0);
      checkOutput("rst busy", 32'(busy_o), 0);
      checkOutput("rst cur_lvl", 32'(cur_lvl_o), 0);
      checkOutput("rst local_lvl", 32'(local_lvl_o), 0);
      checkOutput("rst bkt_lvl", 32'(bkt_lvl_o), 0);
      checkOutput("rst timeout", 32'(analyze_timeout_o), 0);
      tick();
      rst_n = 1'b1;
      tick();

      // Decision table: base 5, three test-plan pushes, fill to 8, full, then none
      vecs[0] = '{8'h01, 1'b0, 10'd3, 1'b0, 1'b0, 4'd1, 16'd6};
      vecs[1] = '{8'h04, 1'b0, 10'd3, 1'b0, 1'b0, 4'd2, 16'd7};
      vecs[2] = '{8'h80, 1'b0, 10'd3, 1'b0, 1'b0, 4'd3, 16'd8};
      vecs[3] = '{8'h02, 1'b0, 10'd3, 1'b0, 1'b0, 4'd4, 16'd9};
      vecs[4] = '{8'h08, 1'b0, 10'd3, 1'b0, 1'b0, 4'd5, 16'd10};
      vecs[5] = '{8'h10, 1'b0, 10'd3, 1'b0, 1'b0, 4'd6, 16'd11};
      vecs[6] = '{8'h20, 1'b0, 10'd3, 1'b0, 1'b0, 4'd7, 16'd12};
      vecs[7] = '{8'h40, 1'b0, 10'd3, 1'b0, 1'b0, 4'd8, 16'd13};
      vecs[8] = '{8'h01, 1'b0, 10'd3, 1'b0, 1'b1, 4'd8, 16'd13};
      vecs[9] = '{8'h01, 1'b1, 10'd3, 1'b1, 1'b0, 4'd8, 16'd13};

      loadBase(16'd5);
      checkOutput("base cur_lvl", 32'(cur_lvl_o), 5);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("dec[%0d] count", i), 32'(cntDec), 1);
         checkOutput($sformatf("dec[%0d] latency", i), 32'(latDec), 2);
         checkOutput($sformatf("dec[%0d] sat", i), 32'(satSeen), 32'(vecs[i].expSat));
         checkOutput($sformatf("dec[%0d] full", i), 32'(fullSeen), 32'(vecs[i].expFull));
         checkOutput($sformatf("dec[%0d] local_lvl", i), 32'(local_lvl_o), 32'(vecs[i].expL));
         checkOutput($sformatf("dec[%0d] cur_lvl", i), 32'(cur_lvl_o), 32'(vecs[i].expCur));
      end

      // Imply: 0x01 then 0x03 held; change in cycle 1, settle of 2 => done in cycle 4
      find_imply_i  = 8'h01;
      apply_imply_i = 1'b1;
      clearObs();
      stepObs(1);
      apply_imply_i = 1'b0;
      find_imply_i  = 8'h03;
      stepObs(8);
      checkOutput("imply step count", 32'(cntImp), 1);
      checkOutput("imply step latency", 32'(latImp), 4);
      checkOutput("imply step conflict", 32'(confSeen), 0);

      // Imply with inputs stable from the request => done in cycle 1+IMPLY_SETTLE
      apply_imply_i = 1'b1;
      clearObs();
      stepObs(1);
      apply_imply_i = 1'b0;
      stepObs(8);
      checkOutput("imply stable latency", 32'(latImp), 3);
      checkOutput("imply stable conflict", 32'(confSeen), 0);

      // Imply with a conflict present => done next cycle with conflict
      find_conflict_i = 8'h10;
      apply_imply_i   = 1'b1;
      clearObs();
      stepObs(1);
      apply_imply_i = 1'b0;
      stepObs(6);
      find_conflict_i = 8'h00;
      checkOutput("imply conflict count", 32'(cntImp), 1);
      checkOutput("imply conflict latency", 32'(latImp), 2);
      checkOutput("imply conflict flag", 32'(confSeen), 1);

      // Local backtrack: base 4, bins 5/7/9 on levels 1..3, learnt max 6
      doReset();
      loadBase(16'd4);
      applyStimulus('{8'h01, 1'b0, 10'd5, 1'b0, 1'b0, 4'd1, 16'd5});
      applyStimulus('{8'h02, 1'b0, 10'd7, 1'b0, 1'b0, 4'd2, 16'd6});
      applyStimulus('{8'h04, 1'b0, 10'd9, 1'b0, 1'b0, 4'd3, 16'd7});
      checkOutput("setup local_lvl", 32'(local_lvl_o), 3);
      cur_bin_num_i = 10'd11;
      doAnalyze(2, 16'd6);
      checkOutput("ana local add count", 32'(cntAdd), 1);
      checkOutput("ana local add latency", 32'(latAdd), 3);
      checkOutput("ana local done latency", 32'(latAna), 4);
      checkOutput("ana local bkt_lvl", 32'(bkt_lvl_o), 6);
      checkOutput("ana local bkt_bin", 32'(bkt_bin_o), 7);
      checkOutput("ana local cross", 32'(bkt_cross_bin_o), 0);
      checkOutput("ana local clamp", 32'(lvl_clamp_o), 0);
      checkOutput("ana local timeout", 32'(analyze_timeout_o), 0);
      doBkt(1'b0);
      checkOutput("bkt local count", 32'(cntBkt), 1);
      checkOutput("bkt local latency", 32'(latBkt), 2);
      checkOutput("bkt local local_lvl", 32'(local_lvl_o), 2);
      checkOutput("bkt local cur_lvl", 32'(cur_lvl_o), 6);

      // Clamp: learnt max 9 => t=5 > L=2, clamped to level 2
      doAnalyze(1, 16'd9);
      checkOutput("ana clamp flag", 32'(lvl_clamp_o), 1);
      checkOutput("ana clamp bkt_lvl", 32'(bkt_lvl_o), 6);
      checkOutput("ana clamp bkt_bin", 32'(bkt_bin_o), 7);

      // Cross-bin: learnt max 3 below base 4; clamp cleared on entry
      doAnalyze(1, 16'd3);
      checkOutput("ana cross flag", 32'(bkt_cross_bin_o), 1);
      checkOutput("ana cross bkt_lvl", 32'(bkt_lvl_o), 3);
      checkOutput("ana cross bkt_bin", 32'(bkt_bin_o), 11);
      checkOutput("ana cross clamp", 32'(lvl_clamp_o), 0);
      doBkt(1'b0);
      checkOutput("bkt cross local_lvl", 32'(local_lvl_o), 0);
      checkOutput("bkt cross cur_lvl", 32'(cur_lvl_o), 4);

      // Timeout: no learnt clause for 64 FIND cycles
      doAnalyze(0, 16'd6);
      checkOutput("timeout add count", 32'(cntAdd), 0);
      checkOutput("timeout done count", 32'(cntAna), 1);
      checkOutput("timeout done latency", 32'(latAna), 65);
      checkOutput("timeout flag", 32'(analyze_timeout_o), 1);
      checkOutput("timeout bkt_lvl held", 32'(bkt_lvl_o), 3);

      // Priority: backtrack wins over a simultaneous decision
      applyStimulus('{8'h01, 1'b0, 10'd11, 1'b0, 1'b0, 4'd1, 16'd5});
      checkOutput("prio setup local_lvl", 32'(local_lvl_o), 1);
      doBkt(1'b1);
      checkOutput("prio bkt count", 32'(cntBkt), 1);
      checkOutput("prio dec count", 32'(cntDec), 0);
      checkOutput("prio local_lvl", 32'(local_lvl_o), 0);

      // Reset during IMPLY: outputs clear immediately, no done pulse afterwards
      applyStimulus('{8'h01, 1'b0, 10'd11, 1'b0, 1'b0, 4'd1, 16'd5});
      find_imply_i  = 8'h01;
      apply_imply_i = 1'b1;
      clearObs();
      stepObs(1);
      apply_imply_i = 1'b0;
      checkOutput("pre-reset busy", 32'(busy_o), 1);
      rst_n = 1'b0;
      #1;
      checkOutput("async rst busy", 32'(busy_o), 0);
      checkOutput("async rst cur_lvl", 32'(cur_lvl_o), 0);
      checkOutput("async rst local_lvl", 32'(local_lvl_o), 0);
      checkOutput("async rst bkt_lvl", 32'(bkt_lvl_o), 0);
      checkOutput("async rst timeout", 32'(analyze_timeout_o), 0);
      tick();
      rst_n = 1'b1;
      stepObs(6);
      checkOutput("rst imply no done", 32'(cntImp), 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
      $finish;
   end

endmodule
